sum_serial_collector: RTL and testbench

//  Downstream stage of the bit-serial adder sum_N*_CC*. It consumes the adder's
//  one-bit-per-cycle sum output c[0], LSB first, and reassembles it into an
//  N-bit parallel word with a valid/ready output handshake.
//  A shift register and a holding register form a ping-pong pair, so the next

---
 rtl/sum_serial_collector.sv | 165 ++++++++++++++++
 tb/tb_sum_serial_collector.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/sum_serial_collector.sv
// Reassembles the LSB-first serial sum stream into N-bit words behind a valid/ready handshake.
// Optional macro SUM_COLLECT_CARRY_EN adds a carry bit that travels with each word.
module sum_serial_collector #(
  parameter int N     = 256,
  parameter int CNT_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         in_valid,
  input  logic         in_bit,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
`ifdef SUM_COLLECT_CARRY_EN
  input  logic         carry_bit,
  output logic         out_carry,
`endif
  output logic         overflow
);

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N-1:0]       sh_q, sh_d;
  logic [N-1:0]       out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               overflow_q, overflow_d;
  logic [N-1:0]       word_s;
  logic               xfer_s;
  logic               last_s;
`ifdef SUM_COLLECT_CARRY_EN
  logic               sh_carry_q, sh_carry_d;
  logic               out_carry_q, out_carry_d;
  logic               carry_in_s;
  assign carry_in_s = carry_bit;
`else
  logic               carry_in_s;
  assign carry_in_s = 1'b0;
`endif

  assign word_s   = {in_bit, sh_q[N-1:1]};
  assign xfer_s   = out_valid_q & out_ready;
  assign last_s   = (cnt_q == CNT_W'(N - 1));
  assign in_ready = (state_q == COLLECT);

  // Next-state, shift/hold datapath and sticky overflow
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    overflow_d  = overflow_q;
`ifdef SUM_COLLECT_CARRY_EN
    sh_carry_d  = sh_carry_q;
    out_carry_d = out_carry_q;
`endif
    case (state_q)
      COLLECT: begin
        if (clr) begin
          cnt_d = {CNT_W{1'b0}};
          sh_d  = {N{1'b0}};
`ifdef SUM_COLLECT_CARRY_EN
          sh_carry_d = 1'b0;
`endif
          if (xfer_s) begin
            out_valid_d = 1'b0;
          end else begin
            out_valid_d = out_valid_q;
          end
        end else if (in_valid && last_s) begin
          cnt_d = {CNT_W{1'b0}};
          if (!out_valid_q || out_ready) begin
            out_data_d  = word_s;
            out_valid_d = 1'b1;
`ifdef SUM_COLLECT_CARRY_EN
            out_carry_d = carry_in_s;
`endif
          end else begin
            // Hold slot busy: park the finished word in the shift register
            sh_d    = word_s;
            state_d = FULL;
`ifdef SUM_COLLECT_CARRY_EN
            sh_carry_d = carry_in_s;
`endif
          end
        end else if (in_valid) begin
          sh_d  = word_s;
          cnt_d = cnt_q + CNT_W'(1);
          if (xfer_s) begin
            out_valid_d = 1'b0;
          end else begin
            out_valid_d = out_valid_q;
          end
        end else begin
          if (xfer_s) begin
            out_valid_d = 1'b0;
          end else begin
            out_valid_d = out_valid_q;
          end
        end
      end
      FULL: begin
        if (xfer_s) begin
          out_data_d = sh_q;
          state_d    = COLLECT;
`ifdef SUM_COLLECT_CARRY_EN
          out_carry_d = sh_carry_q;
`endif
        end else begin
          state_d = FULL;
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
    if (in_valid && (state_q != COLLECT)) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= COLLECT;
      cnt_q       <= {CNT_W{1'b0}};
      sh_q        <= {N{1'b0}};
      out_data_q  <= {N{1'b0}};
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
`ifdef SUM_COLLECT_CARRY_EN
      sh_carry_q  <= 1'b0;
      out_carry_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
`ifdef SUM_COLLECT_CARRY_EN
      sh_carry_q  <= sh_carry_d;
      out_carry_q <= out_carry_d;
`endif
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign overflow  = overflow_q;
`ifdef SUM_COLLECT_CARRY_EN
  assign out_carry = out_carry_q;
`endif

endmodule

// File: tb/tb_sum_serial_collector.sv
// Randomized and directed bench for sum_serial_collector (N=8), checked against a
// word-queue reference model.
module tb_sum_serial_collector;
  localparam int N = 8;

  logic         clk;
  logic         rst;
  logic         clr;
  logic         in_valid;
  logic         in_bit;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic         overflow;
`ifdef SUM_COLLECT_CARRY_EN
  logic         carry_bit;
  logic         out_carry;
`endif

  sum_serial_collector #(.N(N), .CNT_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef SUM_COLLECT_CARRY_EN
    .carry_bit (carry_bit),
    .out_carry (out_carry),
`endif
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: partial bits plus a queue of finished words (at most 2)
  logic [N-1:0] m_part;
  int           m_pcnt;
  logic [N-1:0] m_words[$];
  logic         m_ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_part = '0;
    m_pcnt = 0;
    m_words.delete();
    m_ovf  = 1'b0;
  endtask

  // One clock: drive, compare at negedge, then advance the model across the edge
  task automatic cycle(input logic iv, input logic ib, input logic orr, input logic cl);
    logic         m_ready;
    logic         xfer;
    logic         done;
    logic [N-1:0] w;
    in_valid  = iv;
    in_bit    = ib;
    out_ready = orr;
    clr       = cl;
    m_ready   = (m_words.size() < 2);
    @(negedge clk);
    check("in_ready", in_ready, m_ready);
    check("out_valid", out_valid, m_words.size() > 0);
    check("overflow", overflow, m_ovf);
    if (m_words.size() > 0) check("out_data", out_data, m_words[0]);
`ifdef SUM_COLLECT_CARRY_EN
    if (m_words.size() > 0) check("out_carry", out_carry, 1'b0);
`endif
    @(posedge clk);
    xfer = (m_words.size() > 0) && orr;
    done = 1'b0;
    w    = '0;
    if (iv && !m_ready) m_ovf = 1'b1;
    if (m_ready && cl) begin
      m_part = '0;
      m_pcnt = 0;
    end else if (m_ready && iv) begin
      m_part[m_pcnt] = ib;
      m_pcnt++;
      if (m_pcnt == N) begin
        done   = 1'b1;
        w      = m_part;
        m_part = '0;
        m_pcnt = 0;
      end
    end
    if (xfer) void'(m_words.pop_front());
    if (done) m_words.push_back(w);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic orr);
    for (int i = 0; i < 8; i++) cycle(1'b1, b[i], orr, 1'b0);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
`ifdef SUM_COLLECT_CARRY_EN
    carry_bit = 1'b0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    rst = 1'b0;

    // Reset mid-word with 5 bits collected
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_data", out_data, 8'h00);
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_overflow", overflow, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_byte(8'h3C, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);

    // Single word 0xE1 with latency 1 and single-cycle valid
    send_byte(8'hE1, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    check("single_valid", out_valid, 1'b1);
    check("single_data", out_data, 8'hE1);
    @(posedge clk); #1;
    void'(m_words.pop_front());
    @(negedge clk);
    check("single_valid_drop", out_valid, 1'b0);
    @(posedge clk); #1;

    // Backpressure: two words fill both slots, then overflow attempts
    send_byte(8'hE1, 1'b0);
    send_byte(8'h0F, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("bp_in_ready", in_ready, 1'b0);
    check("bp_overflow", overflow, 1'b1);
    check("bp_hold", out_data, 8'hE1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check("bp_second", out_data, 8'h0F);
    check("bp_second_valid", out_valid, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);

    // clr discards a partial word
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    send_byte(8'h5A, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    check("clr_data", out_data, 8'h5A);
    @(posedge clk); #1;
    void'(m_words.pop_front());

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 3) != 0, 1'($urandom),
            $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
